// File: rtl/pe_stack_bus_upstream_tx_pkg.sv
// rtl/pe_stack_bus_upstream_tx_pkg.sv - shared widths, upstream control codes and header layout
package pe_stack_bus_upstream_tx_pkg;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 8;
    localparam int PE_ID_W = 6;

    localparam int HDR_TAG_LSB   = 0;
    localparam int HDR_PE_ID_LSB = TAG_W;

    typedef enum logic [1:0] {
        STACK_UP_CNTL_IDLE = 2'b00,
        STACK_UP_CNTL_SOM  = 2'b01,
        STACK_UP_CNTL_MOM  = 2'b10,
        STACK_UP_CNTL_EOM  = 2'b11
    } stack_up_cntl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_WAIT,
        ST_DATA
    } tx_state_e;

    typedef struct packed {
        logic               last;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
    } fifo_entry_t;

    function automatic logic [DATA_W-1:0] make_header(input logic [PE_ID_W-1:0] pe_id,
                                                      input logic [TAG_W-1:0]   tag);
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_TAG_LSB +: TAG_W]     = tag;
        hdr[HDR_PE_ID_LSB +: PE_ID_W] = pe_id;
        return hdr;
    endfunction

endpackage

// File: rtl/pe_stack_bus_upstream_tx_if.sv
// rtl/pe_stack_bus_upstream_tx_if.sv - result-side and upstream-side lanes of the PE transmitter
interface pe_stack_bus_upstream_tx_if;
    import pe_stack_bus_upstream_tx_pkg::*;

    logic [PE_ID_W-1:0] sys__pe__peId;
    logic               res__stu__valid;
    logic [DATA_W-1:0]  res__stu__data;
    logic [TAG_W-1:0]   res__stu__tag;
    logic               res__stu__last;
    logic               stu__res__ready;
    logic               pe__stu__valid;
    logic [1:0]         pe__stu__cntl;
    logic [DATA_W-1:0]  pe__stu__data;
    logic               stu__pe__ready;
    logic [15:0]        pe__stu__pktCount;
    logic               pe__stu__lenErr;

    modport master (
        input  sys__pe__peId, res__stu__valid, res__stu__data, res__stu__tag, res__stu__last,
               stu__pe__ready,
        output stu__res__ready, pe__stu__valid, pe__stu__cntl, pe__stu__data,
               pe__stu__pktCount, pe__stu__lenErr
    );

    modport slave (
        output sys__pe__peId, res__stu__valid, res__stu__data, res__stu__tag, res__stu__last,
               stu__pe__ready,
        input  stu__res__ready, pe__stu__valid, pe__stu__cntl, pe__stu__data,
               pe__stu__pktCount, pe__stu__lenErr
    );

endinterface

// File: rtl/pe_stu_tx_fifo.sv
// rtl/pe_stu_tx_fifo.sv - result word buffer; wrap-bit pointers with registered full/empty
module pe_stu_tx_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             full_q, empty_q;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};

    // Empty compares against the pre-write pointer so a new word becomes poppable one
    // cycle after it is written; this never reports data that is not yet in memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_q  <= (wr_ptr_q == rd_ptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/pe_stack_bus_upstream_tx.sv
// rtl/pe_stack_bus_upstream_tx.sv - frames buffered PE results as SOM/MOM/EOM upstream packets
module pe_stack_bus_upstream_tx
    import pe_stack_bus_upstream_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LEN    = 64
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    pe_stack_bus_upstream_tx_if.master bus
);
    localparam int             CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    tx_state_e        state_q, state_d;
    logic             valid_q, valid_d;
    stack_up_cntl_e   cntl_q, cntl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             len_err_q, len_err_d;

    fifo_entry_t      push_entry, head;
    logic [$bits(fifo_entry_t)-1:0] head_raw;
    logic             full, empty, push, pop, xfer;
    logic             load_word, go_quiet, trunc;
    logic [CNT_W-1:0] word_cnt;

    assign push       = bus.res__stu__valid & ~full;
    assign push_entry = '{last: bus.res__stu__last, tag: bus.res__stu__tag, data: bus.res__stu__data};
    assign head       = fifo_entry_t'(head_raw);
    assign xfer       = valid_q & bus.stu__pe__ready;

    pe_stu_tx_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (reset_poweron),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_raw),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            cntl_q    <= STACK_UP_CNTL_IDLE;
            data_q    <= '0;
            dcnt_q    <= '0;
            pkt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cntl_q    <= cntl_d;
            data_q    <= data_d;
            dcnt_q    <= dcnt_d;
            pkt_q     <= pkt_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty) state_d = ST_HDR;
            ST_HDR:  if (xfer) state_d = empty ? ST_WAIT : ST_DATA;
            ST_WAIT: if (!empty) state_d = ST_DATA;
            ST_DATA: begin
                if (xfer) begin
                    if (cntl_q == STACK_UP_CNTL_EOM) state_d = ST_IDLE;
                    else if (empty)                  state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register loads; the head is popped only when a data word enters the register.
    always_comb begin
        valid_d   = valid_q;
        cntl_d    = cntl_q;
        data_d    = data_q;
        dcnt_d    = dcnt_q;
        pkt_d     = pkt_q;
        len_err_d = len_err_q;
        load_word = 1'b0;
        go_quiet  = 1'b0;
        word_cnt  = dcnt_q + CNT_W'(1);
        trunc     = (word_cnt == MAX_CNT) && !head.last;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    valid_d = 1'b1;
                    cntl_d  = STACK_UP_CNTL_SOM;
                    data_d  = make_header(bus.sys__pe__peId, head.tag);
                    dcnt_d  = '0;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    load_word = !empty;
                    go_quiet  = empty;
                end
            end
            ST_WAIT: load_word = !empty;
            ST_DATA: begin
                if (xfer) begin
                    if (cntl_q == STACK_UP_CNTL_EOM) begin
                        pkt_d    = pkt_q + 16'd1;
                        go_quiet = 1'b1;
                    end else begin
                        load_word = !empty;
                        go_quiet  = empty;
                    end
                end
            end
            default: go_quiet = 1'b1;
        endcase
        if (load_word) begin
            valid_d = 1'b1;
            data_d  = head.data;
            cntl_d  = (head.last || trunc) ? STACK_UP_CNTL_EOM : STACK_UP_CNTL_MOM;
            dcnt_d  = word_cnt;
            if (trunc) len_err_d = 1'b1;
        end
        if (go_quiet) begin
            valid_d = 1'b0;
            cntl_d  = STACK_UP_CNTL_IDLE;
            data_d  = '0;
        end
        pop = load_word;
    end

    assign bus.stu__res__ready   = ~full;
    assign bus.pe__stu__valid    = valid_q;
    assign bus.pe__stu__cntl     = cntl_q;
    assign bus.pe__stu__data     = data_q;
    assign bus.pe__stu__pktCount = pkt_q;
    assign bus.pe__stu__lenErr   = len_err_q;

endmodule

// File: tb/tb_pe_stack_bus_upstream_tx.sv
// tb/tb_pe_stack_bus_upstream_tx.sv - directed bench with a packet-framing reference model
module tb_pe_stack_bus_upstream_tx;
    import pe_stack_bus_upstream_tx_pkg::*;

    localparam int MAX_LEN = 64;
    localparam int DEPTH   = 8;
    localparam logic [1:0] C_IDLE = 2'b00, C_SOM = 2'b01, C_MOM = 2'b10, C_EOM = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_stack_bus_upstream_tx_if bus();

    pe_stack_bus_upstream_tx #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk           (clk),
        .reset_poweron (rst),
        .bus           (bus)
    );

    typedef struct {
        logic               last;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
    } src_t;

    typedef struct {
        logic [1:0]         cntl;
        logic [DATA_W-1:0]  data;
        bit                 forced;
    } up_t;

    src_t       src_q[$];
    up_t        exp_q[$];
    logic [1:0] xlog[$];
    bit         rdy;
    int         checks, errors;
    bit         in_pkt, exp_err, prev_hold;
    int         wcnt, exp_pkts;
    logic [1:0] prev_cntl;
    logic [DATA_W-1:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference framing: header on the first word of a packet, EOM on last or the MAX_LEN-th word.
    task automatic model_push(input src_t w);
        logic [DATA_W-1:0] hdr;
        if (!in_pkt) begin
            hdr = {{(DATA_W-PE_ID_W-TAG_W){1'b0}}, bus.sys__pe__peId, w.tag};
            exp_q.push_back('{C_SOM, hdr, 1'b0});
            in_pkt = 1'b1;
            wcnt   = 0;
        end
        wcnt++;
        if (w.last || wcnt == MAX_LEN) begin
            exp_q.push_back('{C_EOM, w.data, !w.last});
            in_pkt = 1'b0;
        end else begin
            exp_q.push_back('{C_MOM, w.data, 1'b0});
        end
    endtask

    task automatic monitor();
        up_t e;
        bit  exp_len;
        if (rst) begin
            exp_q.delete();
            in_pkt = 0; wcnt = 0; exp_pkts = 0; exp_err = 0; prev_hold = 0;
            return;
        end
        chk("pktCount", 64'(bus.pe__stu__pktCount), 64'(exp_pkts & 16'hFFFF));
        exp_len = exp_err || (bus.pe__stu__valid && exp_q.size() > 0 && exp_q[0].forced);
        chk("lenErr", 64'(bus.pe__stu__lenErr), 64'(exp_len));
        if (prev_hold) begin
            chk("hold_valid", 64'(bus.pe__stu__valid), 64'd1);
            chk("hold_cntl", 64'(bus.pe__stu__cntl), 64'(prev_cntl));
            chk("hold_data", 64'(bus.pe__stu__data), 64'(prev_data));
        end
        if (!bus.pe__stu__valid) chk("idle_cntl", 64'(bus.pe__stu__cntl), 64'(C_IDLE));
        if (bus.pe__stu__valid && bus.stu__pe__ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("up_cntl", 64'(bus.pe__stu__cntl), 64'(e.cntl));
                chk("up_data", 64'(bus.pe__stu__data), 64'(e.data));
                xlog.push_back(bus.pe__stu__cntl);
                if (e.cntl == C_EOM) exp_pkts++;
                if (e.forced) exp_err = 1'b1;
            end
        end
        prev_hold = bus.pe__stu__valid && !bus.stu__pe__ready;
        prev_cntl = bus.pe__stu__cntl;
        prev_data = bus.pe__stu__data;
        if (bus.res__stu__valid && bus.stu__res__ready && src_q.size() > 0) begin
            model_push(src_q.pop_front());
        end
    endtask

    task automatic drive();
        if (src_q.size() > 0) begin
            bus.res__stu__valid = 1'b1;
            bus.res__stu__data  = src_q[0].data;
            bus.res__stu__tag   = src_q[0].tag;
            bus.res__stu__last  = src_q[0].last;
        end else begin
            bus.res__stu__valid = 1'b0;
            bus.res__stu__data  = '0;
            bus.res__stu__tag   = '0;
            bus.res__stu__last  = 1'b0;
        end
        bus.stu__pe__ready = rdy;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic send(input int n, input logic [DATA_W-1:0] base, input logic [TAG_W-1:0] tag,
                        input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            src_q.push_back('{(last_on_final && i == n - 1), tag, base + DATA_W'(i)});
        end
        drive();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.pe__stu__valid && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_valid_timeout", 64'(bus.pe__stu__valid), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] seq;
        int         soms;
        checks = 0; errors = 0;
        rst = 1'b1; rdy = 1'b1;
        bus.sys__pe__peId = 6'd5;
        drive();
        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_valid", 64'(bus.pe__stu__valid), 64'd0);
        chk("rst_cntl", 64'(bus.pe__stu__cntl), 64'd0);
        chk("rst_data", 64'(bus.pe__stu__data), 64'd0);
        chk("rst_pktCount", 64'(bus.pe__stu__pktCount), 64'd0);
        chk("rst_lenErr", 64'(bus.pe__stu__lenErr), 64'd0);
        chk("rst_res_ready", 64'(bus.stu__res__ready), 64'd1);

        // single word: header after N+2, EOM after N+3
        send(1, 32'hA5A5A5A5, 8'h03, 1'b1);
        repeat (2) cycle();
        chk("t1_lat_valid_n1", 64'(bus.pe__stu__valid), 64'd0);
        cycle();
        chk("t1_hdr_valid", 64'(bus.pe__stu__valid), 64'd1);
        chk("t1_hdr_cntl", 64'(bus.pe__stu__cntl), 64'(C_SOM));
        chk("t1_hdr_data", 64'(bus.pe__stu__data), 64'h0000_0503);
        cycle();
        chk("t1_eom_cntl", 64'(bus.pe__stu__cntl), 64'(C_EOM));
        chk("t1_eom_data", 64'(bus.pe__stu__data), 64'hA5A5_A5A5);
        repeat (2) cycle();
        chk("t1_pktCount", 64'(bus.pe__stu__pktCount), 64'd1);

        // four words, header back-pressured for three cycles
        xlog.delete();
        rdy = 1'b0;
        send(4, 32'h100, 8'h07, 1'b1);
        wait_valid(20);
        chk("t2_hdr_data", 64'(bus.pe__stu__data), 64'h0000_0507);
        repeat (3) cycle();
        rdy = 1'b1;
        drive();
        drain(40);
        chk("t2_xfers", 64'(xlog.size()), 64'd5);
        seq = '0;
        for (int i = 0; i < 5 && i < xlog.size(); i++) seq = {seq[7:0], xlog[i]};
        chk("t2_seq", 64'(seq), 64'(10'b01_10_10_10_11));
        chk("t2_pktCount", 64'(bus.pe__stu__pktCount), 64'd2);

        // fill the buffer past its depth
        rdy = 1'b0;
        send(9, 32'h200, 8'h09, 1'b0);
        repeat (14) cycle();
        chk("t3_res_ready_full", 64'(bus.stu__res__ready), 64'd0);
        chk("t3_src_left", 64'(src_q.size()), 64'd1);
        rdy = 1'b1;
        send(1, 32'h2FF, 8'h09, 1'b1);
        drain(60);
        chk("t3_pktCount", 64'(bus.pe__stu__pktCount), 64'd3);

        // source starvation mid-packet
        xlog.delete();
        send(1, 32'h300, 8'h0B, 1'b0);
        repeat (8) cycle();
        chk("t4_wait_valid", 64'(bus.pe__stu__valid), 64'd0);
        chk("t4_sent", 64'(xlog.size()), 64'd2);
        repeat (2) cycle();
        chk("t4_wait_valid2", 64'(bus.pe__stu__valid), 64'd0);
        send(2, 32'h301, 8'h0B, 1'b1);
        drain(40);
        chk("t4_pktCount", 64'(bus.pe__stu__pktCount), 64'd4);

        // 65-word result truncated at MAX_LEN
        xlog.delete();
        send(65, 32'h1000, 8'h1C, 1'b1);
        drain(200);
        chk("t5_lenErr", 64'(bus.pe__stu__lenErr), 64'd1);
        chk("t5_pktCount", 64'(bus.pe__stu__pktCount), 64'd6);
        soms = 0;
        foreach (xlog[i]) if (xlog[i] == C_SOM) soms++;
        chk("t5_som_count", 64'(soms), 64'd2);
        chk("t5_xfers", 64'(xlog.size()), 64'd67);

        // reset while in DATA with two words buffered
        rdy = 1'b0;
        send(3, 32'h400, 8'h2A, 1'b0);
        wait_valid(20);
        rdy = 1'b1;
        drive();
        cycle();
        rdy = 1'b0;
        drive();
        chk("t6_in_data", 64'(bus.pe__stu__cntl), 64'(C_MOM));
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 64'(bus.pe__stu__valid), 64'd0);
        chk("t6_async_cntl", 64'(bus.pe__stu__cntl), 64'd0);
        src_q.delete();
        drive();
        repeat (2) cycle();
        rst = 1'b0;
        chk("t6_res_ready", 64'(bus.stu__res__ready), 64'd1);
        chk("t6_pktCount_clr", 64'(bus.pe__stu__pktCount), 64'd0);
        chk("t6_lenErr_clr", 64'(bus.pe__stu__lenErr), 64'd0);
        xlog.delete();
        rdy = 1'b1;
        send(1, 32'h500, 8'h11, 1'b1);
        drain(40);
        chk("t6_first_som", 64'(xlog.size() > 0 ? xlog[0] : C_IDLE), 64'(C_SOM));
        chk("t6_pktCount", 64'(bus.pe__stu__pktCount), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
